// File: rtl/demux1_7_buf.sv
// Buffered 1-to-7 distributor: 2-entry FIFO of {sel,data}, sel 7 dropped.
// Define DEMUX7_DROPCNT_EN to add the saturating drop_count output.
module demux1_7_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [6:0]       out_valid,
  input  logic [6:0]       out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_sel,
  output logic             drop_err
`ifdef DEMUX7_DROPCNT_EN
  ,
  output logic [7:0]       drop_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  occ_e             occ_q, occ_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [2:0]       sel_q  [2];
  logic [2:0]       sel_d  [2];
  logic [WIDTH-1:0] data_q [2];
  logic [WIDTH-1:0] data_d [2];

  logic             has_head;
  logic             drop;
  logic             push;
  logic             pop;
  logic [2:0]       head_sel;
  logic [WIDTH-1:0] head_data;

  always_comb begin
    head_sel  = sel_q[rd_ptr_q];
    head_data = data_q[rd_ptr_q];
    has_head  = occ_q != EMPTY;
    in_ready  = occ_q != occ_e'(FULL_CNT);
    push      = in_valid && in_ready;
    drop      = has_head && (head_sel == 3'd7);
    out_valid = 7'd0;
    out_data  = '0;
    out_sel   = 3'd0;
    if (has_head) begin
      out_data = head_data;
      out_sel  = head_sel;
      if (!drop) out_valid = 7'd1 << head_sel;
    end
    drop_err = drop;
    // Non-selected lanes' ready bits are masked by the one-hot valid
    pop = drop || (|(out_valid & out_ready));
  end

  always_comb begin
    sel_d    = sel_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    occ_d    = occ_q;
    if (push) begin
      sel_d[wr_ptr_q]  = in_sel;
      data_d[wr_ptr_q] = in_data;
    end
    unique case (occ_q)
      EMPTY:   if (push) occ_d = ONE;
      ONE: begin
        if (push && !pop)      occ_d = FULL;
        else if (pop && !push) occ_d = EMPTY;
      end
      FULL:    if (pop) occ_d = ONE;
      default: occ_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q     <= EMPTY;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      sel_q[0]  <= 3'd0;
      sel_q[1]  <= 3'd0;
      data_q[0] <= '0;
      data_q[1] <= '0;
    end else begin
      occ_q     <= occ_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
    end
  end

`ifdef DEMUX7_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt_q <= 8'd0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: doc/demux1_7_buf.md
# demux1_7_buf

Buffered 1-to-7 data distributor: accepts a 32-bit word tagged with a 3-bit destination selector and delivers it to exactly one of seven consumers over per-destination valid/ready handshakes. It is the fan-out counterpart of the 7-input selector mux in the datapath, routing one source to a selected sink rather than picking one source. A 2-entry FIFO decouples the producer from consumer stalls. Selector 3'b111 has no destination; such words are dropped and flagged.

## Interface
- WIDTH, 32, data width of payload
- DEPTH, 2, FIFO entries (fixed at 2; other values unsupported)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  producer has a word
- in_ready  out  1  block can accept a word this cycle
- in_sel  in  3  destination index 0..6; 7 = invalid
- in_data  in  WIDTH  payload
- out_valid  out  7  one-hot (or zero) valid per destination
- out_ready  in  7  per-destination ready
- out_data  out  WIDTH  shared payload bus, meaningful only where out_valid bit set
- out_sel  out  3  selector of head entry (debug/observability)
- drop_err  out  1  one-cycle pulse when an invalid-selector word is discarded
- drop_count  out  8  saturating count of dropped words (only with DEMUX7_DROPCNT_EN)

## Operation
- Storage: 2-entry circular FIFO of {sel, data}; write pointer, read pointer (1 bit each), occupancy count 0..2.
- Occupancy states: EMPTY (0), ONE (1), FULL (2).
- Push: in_valid && in_ready. in_ready = (count != 2); depends only on registered state, never on out_ready.
- Head presentation (count != 0):
  - head.sel in 0..6: out_valid[head.sel]=1, all other bits 0; out_data=head.data; out_sel=head.sel.
  - head.sel == 7: out_valid = 7'b0; entry popped unconditionally that cycle; drop_err=1 that cycle.
- Pop: (head valid sel && out_ready[head.sel]) or (head.sel == 7). out_ready bits of non-selected lanes ignored.
- Simultaneous push+pop: allowed in ONE (count stays 1) and in EMPTY is impossible (no pop). In FULL, in_ready=0, so only pop occurs -> ONE.
- Transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; FULL->ONE on pop.
- When count == 0: out_valid=0, out_data=0, out_sel=0, drop_err=0.
- Order preserved: words leave in acceptance order regardless of destination.

## Timing
- Reset (asynchronous assert, low): count=0, pointers=0, in_ready=1 after release, out_valid=0, out_data=0, out_sel=0, drop_err=0, drop_count=0. Reset mid-transfer discards all stored entries; nothing is replayed.
- Latency: word accepted at edge N is presented at cycle N+1 (no combinational bypass from in_* to out_*).
- Throughput: one word per cycle sustained when the head's consumer holds ready high.
- Dropped word consumes one head cycle; drop_err is combinational from head state, aligned with that cycle.
- out_valid/out_data stable while the head's destination holds ready low.

## Configuration
- DEMUX7_DROPCNT_EN defined: drop_count port present; increments by 1 on every drop_err cycle, saturates at 8'hFF, cleared only by reset.
- Not defined: drop_count port and counter absent; drop_err behaviour unchanged.

## Test plan
- Reset then idle -> in_ready=1, out_valid=7'b0, out_data=0, drop_err=0.
- Push {sel=3, data=32'hCAFE0003} with out_ready=7'h7F -> next cycle out_valid=7'b0001000, out_data=32'hCAFE0003; popped same cycle; count back to 0.
- out_ready=0; push sel=0 then sel=6 -> in_ready=0 after second push; third in_valid refused; raise out_ready[6] only -> no pop (head is sel 0); raise out_ready[0] -> sel 0 delivered, then sel 6 delivered in order.
- Push sel=7 data=32'h1 -> one cycle later drop_err=1, out_valid=0, FIFO empties; with DEMUX7_DROPCNT_EN drop_count=1; 300 drops -> drop_count=8'hFF.
- Back-to-back pushes sel=1,2,4,5 with all ready high -> four consecutive delivery cycles, one word per cycle, correct one-hot each cycle.
- Assert reset low while FULL -> out_valid=0 and count=0 immediately (asynchronous); after release, no stale words appear.
